// File: rtl/gate_sweep_checker.sv
// Sweeps the four {a,b} input combinations into a two-input gate block, waits SETTLE
// cycles after each one, and checks the block's seven outputs against the golden truth table.
module gate_sweep_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic [6:0] y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [6:0] err_vec,
  output logic [1:0] fail_idx
);

  // Handshake: start is a level request, accepted only on an IDLE cycle; done is a
  // single-cycle pulse and the result fields stay stable until the next accepted start.
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [1:0] combo;
  logic [3:0] cnt;
  logic [6:0] golden;
  logic [6:0] diff;
  logic       mism;

  always_comb begin
    golden = 7'h59;
    case (combo)
      2'd0: golden = 7'h59;
      2'd1: golden = 7'h2D;
      2'd2: golden = 7'h2C;
      2'd3: golden = 7'h46;
      default: golden = 7'h59;
    endcase
  end

  // Case inequality so an X on y_in during SAMPLE is flagged rather than silently passed.
  assign diff = y_in ^ golden;
  assign mism = (y_in !== golden);

  assign a_out = combo[1];
  assign b_out = combo[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      combo     <= 2'd0;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      err_vec   <= 7'd0;
      fail_idx  <= 2'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            combo     <= 2'd0;
            cnt       <= 4'd0;
            err_count <= 3'd0;
            err_vec   <= 7'd0;
            fail_idx  <= 2'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (mism) begin
            err_count <= err_count + 3'd1;
            err_vec   <= err_vec | diff;
            if (err_count == 3'd0) fail_idx <= combo;
          end
          if (combo == 2'd3) begin
            // pass is registered on entry to DONE so it is already valid in the done cycle.
            pass  <= (err_count == 3'd0) && !mism;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            combo <= combo + 2'd1;
            cnt   <= 4'd0;
            state <= S_SETTLE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (SETTLE=2 and SETTLE=1) each driving a
// configurable faulty/delayed gate model, checked against a truth-table reference.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [2:0] ec_s    [2];
  logic [6:0] ev_s    [2];
  logic [1:0] fi_s    [2];
  logic [6:0] y_s     [2];
  logic [6:0] d1      [2];
  logic [6:0] d2      [2];

  logic [6:0] sa0 = 7'h00;
  logic [6:0] sa1 = 7'h00;
  logic [6:0] flip = 7'h00;
  bit         delay_on = 1'b0;
  int         last_combo [2];
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  gate_sweep_checker #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_s[0]), .a_out(a_s[0]), .b_out(b_s[0]),
    .y_in(y_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(ec_s[0]), .err_vec(ev_s[0]), .fail_idx(fi_s[0])
  );

  gate_sweep_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .a_out(a_s[1]), .b_out(b_s[1]),
    .y_in(y_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(ec_s[1]), .err_vec(ev_s[1]), .fail_idx(fi_s[1])
  );

  // Golden truth from the gate equations themselves (bit6 down to bit0).
  function automatic logic [6:0] gold(input int ab);
    logic a, b;
    a = ab[1];
    b = ab[0];
    return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b, ~a};
  endfunction

  function automatic logic [6:0] faulty(input logic [6:0] g, input logic [6:0] s0,
                                        input logic [6:0] s1, input logic [6:0] fl);
    return ((g & ~s0) | s1) ^ fl;
  endfunction

  // Gate model: combinational, or two register stages of latency when delay_on is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      d1[k] <= faulty(gold({30'd0, a_s[k], b_s[k]}), sa0, sa1, flip);
      d2[k] <= d1[k];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      y_s[k] = faulty(gold({30'd0, a_s[k], b_s[k]}), sa0, sa1, flip);
      if (delay_on) y_s[k] = d2[k];
    end
  end

  // Expected {pass, err_count, err_vec, fail_idx}. A model whose latency exceeds the
  // settle time shows, at each sample, the response to the previously driven combination.
  function automatic logic [12:0] ref_sweep(input int settle, input int dly, input int prev);
    int         n;
    int         first;
    int         src;
    logic [6:0] vec;
    logic [6:0] d;
    n = 0;
    first = -1;
    vec = 7'd0;
    for (int c = 0; c < 4; c++) begin
      src = (dly > settle) ? ((c == 0) ? prev : c - 1) : c;
      d = faulty(gold(src), sa0, sa1, flip) ^ gold(c);
      if (d != 7'd0) begin
        if (first < 0) first = c;
        n++;
        vec |= d;
      end
    end
    return {(n == 0), 3'(n), vec, 2'((first < 0) ? 0 : first)};
  endfunction

  task automatic run_sweep(input int k, input int settle, input bit pulse_mid);
    logic [12:0] exp_res;
    logic [12:0] got_res;
    int          n_cyc;
    exp_res = ref_sweep(settle, delay_on ? 2 : 0, last_combo[k]);
    n_cyc = 4 * (settle + 1);
    repeat (3) @(negedge clk);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    for (int i = 0; i <= n_cyc + 3; i++) begin
      got_res = {pass_s[k], ec_s[k], ev_s[k], fi_s[k]};
      checks++;
      if (i < n_cyc) begin
        if ({busy_s[k], done_s[k], a_s[k], b_s[k]} !== {1'b1, 1'b0, 2'(i / (settle + 1))}) begin
          failures++;
          $display("FAIL sweep_trace dut%0d cyc%0d: busy,done,a,b=%b%b%b%b required %b%b%02b",
                   k, i, busy_s[k], done_s[k], a_s[k], b_s[k], 1'b1, 1'b0, 2'(i / (settle + 1)));
        end
      end else if (i == n_cyc) begin
        if ({busy_s[k], done_s[k], a_s[k], b_s[k]} !== 4'b0111) begin
          failures++;
          $display("FAIL done_cycle dut%0d: busy,done,a,b=%b%b%b%b required 0111",
                   k, busy_s[k], done_s[k], a_s[k], b_s[k]);
        end
        checks++;
        if (got_res !== exp_res) begin
          failures++;
          $display("FAIL result dut%0d: pass,ec,ev,fi=%b,%0d,%h,%0d required %b,%0d,%h,%0d", k,
                   got_res[12], got_res[11:9], got_res[8:2], got_res[1:0],
                   exp_res[12], exp_res[11:9], exp_res[8:2], exp_res[1:0]);
        end
      end else begin
        if ({busy_s[k], done_s[k], got_res} !== {2'b00, exp_res}) begin
          failures++;
          $display("FAIL after_done dut%0d cyc%0d: busy,done=%b%b res=%h required 00 res=%h",
                   k, i, busy_s[k], done_s[k], got_res, exp_res);
        end
      end
      // A start raised mid-sweep and in the done cycle must be ignored.
      start_s[k] = pulse_mid && (i == 5 || i == n_cyc);
      @(negedge clk);
    end
    start_s[k] = 1'b0;
    last_combo[k] = 3;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({a_s[k], b_s[k], busy_s[k], done_s[k], pass_s[k], ec_s[k], ev_s[k], fi_s[k]} !== 17'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d: outputs=%h required 0", k,
                 {a_s[k], b_s[k], busy_s[k], done_s[k], pass_s[k], ec_s[k], ev_s[k], fi_s[k]});
      end
    end
    rst = 1'b0;
    last_combo[0] = 0;
    last_combo[1] = 0;
  endtask

  task automatic test_correct;
    {sa0, sa1, flip, delay_on} = '0;
    run_sweep(0, 2, 1'b0);
    run_sweep(1, 1, 1'b0);
  endtask

  task automatic test_stuck_faults;
    {sa0, sa1, flip, delay_on} = '0;
    sa0 = 7'h20;
    run_sweep(0, 2, 1'b0);
    sa0 = 7'h00;
    sa1 = 7'h02;
    run_sweep(0, 2, 1'b0);
    sa1 = 7'h00;
  endtask

  task automatic test_latency;
    {sa0, sa1, flip} = '0;
    delay_on = 1'b1;
    run_sweep(0, 2, 1'b0);
    run_sweep(1, 1, 1'b0);
    checks++;
    if (ec_s[1] == 3'd0 || pass_s[1] !== 1'b0) begin
      failures++;
      $display("FAIL latency_short_settle: ec=%0d pass=%b required ec>=1 pass=0", ec_s[1], pass_s[1]);
    end
    delay_on = 1'b0;
  endtask

  task automatic test_busy_restart;
    {sa0, sa1, flip, delay_on} = '0;
    sa0 = 7'h01;
    run_sweep(0, 2, 1'b1);
    sa0 = 7'h00;
  endtask

  task automatic test_back_to_back;
    int n;
    {sa0, sa1, flip, delay_on} = '0;
    @(negedge clk);
    start_s[0] = 1'b1;
    n = 0;
    while (done_s[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_s[0] !== 1'b1 && n < 60);
    start_s[0] = 1'b0;
    checks++;
    if (n != 14) begin
      failures++;
      $display("FAIL back_to_back_period: got %0d cycles required 14", n);
    end
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_s[0] === 1'b1 || busy_s[0] === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL back_to_back_stop: got %0d active cycles required 0", n);
    end
    last_combo[0] = 3;
  endtask

  task automatic test_reset_mid;
    int n;
    {sa0, sa1, flip, delay_on} = '0;
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0], ec_s[0], ev_s[0], fi_s[0]} !== 17'd0) begin
      failures++;
      $display("FAIL reset_mid_sweep: outputs=%h required 0",
               {a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0], ec_s[0], ev_s[0], fi_s[0]});
    end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_s[0] === 1'b1 || busy_s[0] === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL reset_no_done: got %0d active cycles required 0", n);
    end
    last_combo[0] = 0;
    last_combo[1] = 0;
    run_sweep(0, 2, 1'b0);
  endtask

  task automatic test_random;
    int k;
    for (int it = 0; it < 12; it++) begin
      sa0 = 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127));
      sa1 = 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127));
      flip = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h00;
      delay_on = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 1);
      run_sweep(k, (k == 0) ? 2 : 1, 1'($urandom_range(0, 1)));
    end
    {sa0, sa1, flip, delay_on} = '0;
  endtask

  initial begin
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    test_reset;
    test_correct;
    test_stuck_faults;
    test_latency;
    test_busy_restart;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
